// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage: FSM state encoding, reset PC default,
// the J opcode and the branch offset helper.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        HOLD  = 2'b10
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [5:0]  OPC_J            = 6'b000010;

    // Word-scaled, sign-extended branch displacement.
    function automatic logic signed [31:0] br_offset(input logic [15:0] imm);
        br_offset = {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_stage_next_pc_calc.sv
// Combinational next-PC selection for the instruction being consumed.
// Jump has priority over a taken branch; all arithmetic wraps at 32 bits.
module next_pc_calc
    import cpu_pkg::*;
(
    input  logic [31:0] i_ir_pc,
    input  logic        i_jump,
    input  logic        i_branch_taken,
    input  logic [15:0] i_br_imm,
    input  logic [25:0] i_j_target,
    output logic [31:0] o_next_pc,
    output logic [31:0] o_pc_plus4
);

    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_target;
    logic [31:0] w_j_target;

    assign w_pc_plus4  = i_ir_pc + 32'd4;
    assign w_br_target = w_pc_plus4 + $unsigned(br_offset(i_br_imm));
    assign w_j_target  = {w_pc_plus4[31:28], i_j_target, 2'b00};

    always_comb begin
        o_next_pc = w_pc_plus4;
        if (i_jump) begin
            o_next_pc = w_j_target;
        end else if (i_branch_taken) begin
            o_next_pc = w_br_target;
        end
    end

    assign o_pc_plus4 = w_pc_plus4;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: holds the PC, fetches over a req/ack memory port and
// hands the instruction to the decoder over a valid/ready handshake.
module if_fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      ir,
    output logic [31:0]      ir_pc,
    output logic             ir_valid,
    input  logic             ir_ready,
    input  logic             jump,
    input  logic             branch_taken,
    input  logic [15:0]      br_imm,
    input  logic [25:0]      j_target,
    output logic [31:0]      pc_plus4,
    output logic [CNT_W-1:0] retired_cnt
);

    fetch_state_e     r_state;
    fetch_state_e     w_state_next;
    logic [31:0]      r_pc;
    logic [31:0]      r_ir;
    logic [31:0]      r_ir_pc;
    logic             r_ir_valid;
    logic [CNT_W-1:0] r_retired_cnt;
    logic [31:0]      w_next_pc;
    logic             w_fetch_done;
    logic             w_consume;

    assign w_fetch_done = (r_state == FETCH) && imem_ack;
    assign w_consume    = (r_state == HOLD) && r_ir_valid && ir_ready;

    next_pc_calc u_next_pc_calc (
        .i_ir_pc        (r_ir_pc),
        .i_jump         (jump),
        .i_branch_taken (branch_taken),
        .i_br_imm       (br_imm),
        .i_j_target     (j_target),
        .o_next_pc      (w_next_pc),
        .o_pc_plus4     (pc_plus4)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    w_state_next = FETCH;
            FETCH:   if (imem_ack) w_state_next = HOLD;
            HOLD:    if (w_consume) w_state_next = FETCH;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        imem_req = 1'b0;
        if (r_state == FETCH) begin
            imem_req = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_ir          <= '0;
            r_ir_pc       <= '0;
            r_ir_valid    <= 1'b0;
            r_retired_cnt <= '0;
        end else begin
            if (w_fetch_done) begin
                r_ir       <= imem_rdata;
                r_ir_pc    <= r_pc;
                r_ir_valid <= 1'b1;
            end
            // PC only advances once the decoder has taken the instruction.
            if (w_consume) begin
                r_ir_valid    <= 1'b0;
                r_retired_cnt <= r_retired_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                r_pc          <= w_next_pc;
            end
        end
    end

    assign imem_addr   = r_pc;
    assign ir          = r_ir;
    assign ir_pc       = r_ir_pc;
    assign ir_valid    = r_ir_valid;
    assign retired_cnt = r_retired_cnt;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: reset, sequential/branch/jump redirects,
// stalls with spurious acks, reset during a fetch and PC wrap-around.
module tb_if_fetch_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        jump;
    logic        branch_taken;
    logic [15:0] br_imm;
    logic [25:0] j_target;
    logic [31:0] pc_plus4;
    logic [31:0] retired_cnt;

    logic        h_imem_req;
    logic [31:0] h_imem_addr;
    logic        h_imem_ack;
    logic [31:0] h_imem_rdata;
    logic [31:0] h_ir;
    logic [31:0] h_ir_pc;
    logic        h_ir_valid;
    logic        h_ir_ready;
    logic [31:0] h_pc_plus4;
    logic [31:0] h_retired_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .ir           (ir),
        .ir_pc        (ir_pc),
        .ir_valid     (ir_valid),
        .ir_ready     (ir_ready),
        .jump         (jump),
        .branch_taken (branch_taken),
        .br_imm       (br_imm),
        .j_target     (j_target),
        .pc_plus4     (pc_plus4),
        .retired_cnt  (retired_cnt)
    );

    // Second instance starting in the 0x4xxx_xxxx region to exercise jump upper bits.
    if_fetch_stage #(.RESET_PC(32'h4000_0010)) dut_hi (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (h_imem_req),
        .imem_addr    (h_imem_addr),
        .imem_ack     (h_imem_ack),
        .imem_rdata   (h_imem_rdata),
        .ir           (h_ir),
        .ir_pc        (h_ir_pc),
        .ir_valid     (h_ir_valid),
        .ir_ready     (h_ir_ready),
        .jump         (jump),
        .branch_taken (branch_taken),
        .br_imm       (br_imm),
        .j_target     (j_target),
        .pc_plus4     (h_pc_plus4),
        .retired_cnt  (h_retired_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [31:0] data);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req) begin
                imem_ack   = 1'b1;
                imem_rdata = data;
                step();
                imem_ack   = 1'b0;
                ok = 1'b1;
                break;
            end
            step();
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL fetch_timeout: imem_req got %b want 1 within 20 cycles", imem_req);
        end
    endtask

    task automatic consume(input logic j, input logic b, input logic [15:0] imm, input logic [25:0] tgt);
        ir_ready     = 1'b1;
        jump         = j;
        branch_taken = b;
        br_imm       = imm;
        j_target     = tgt;
        step();
        ir_ready     = 1'b0;
        jump         = 1'b0;
        branch_taken = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rst_req: got %b want 0", imem_req); end
        tests++; if (ir_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", ir_valid); end
        tests++; if (ir !== 32'h0) begin fails++; $display("FAIL rst_ir: got %h want 0", ir); end
        tests++; if (ir_pc !== 32'h0) begin fails++; $display("FAIL rst_ir_pc: got %h want 0", ir_pc); end
        tests++; if (retired_cnt !== 32'h0) begin fails++; $display("FAIL rst_cnt: got %0d want 0", retired_cnt); end
        rst_n = 1'b1;
        step();
        tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL first_req: got %b want 1", imem_req); end
        tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL first_addr: got %h want 0", imem_addr); end
        step();
        step();
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin fails++; $display("FAIL wait_req: got req=%b addr=%h want 1/0", imem_req, imem_addr); end
        imem_ack   = 1'b1;
        imem_rdata = 32'h2008_0005;
        step();
        imem_ack   = 1'b0;
        tests++; if (ir !== 32'h2008_0005) begin fails++; $display("FAIL first_ir: got %h want 20080005", ir); end
        tests++; if (ir_valid !== 1'b1) begin fails++; $display("FAIL first_valid: got %b want 1", ir_valid); end
        tests++; if (ir_pc !== 32'h0) begin fails++; $display("FAIL first_ir_pc: got %h want 0", ir_pc); end
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL req_drop: got %b want 0", imem_req); end
    endtask

    task automatic test_sequential();
        consume(1'b1, 1'b0, 16'h0, 26'h40);
        tests++; if (imem_addr !== 32'h100) begin fails++; $display("FAIL jmp_to_100: got %h want 100", imem_addr); end
        tests++; if (ir_valid !== 1'b0) begin fails++; $display("FAIL consume_valid: got %b want 0", ir_valid); end
        do_fetch(32'h0000_0020);
        tests++; if (ir_pc !== 32'h100) begin fails++; $display("FAIL seq_ir_pc: got %h want 100", ir_pc); end
        tests++; if (pc_plus4 !== 32'h104) begin fails++; $display("FAIL seq_pc_plus4: got %h want 104", pc_plus4); end
        tests++; if (retired_cnt !== 32'd1) begin fails++; $display("FAIL seq_cnt_before: got %0d want 1", retired_cnt); end
        consume(1'b0, 1'b0, 16'h1234, 26'h3FF_FFFF);
        tests++; if (imem_addr !== 32'h104) begin fails++; $display("FAIL seq_addr: got %h want 104", imem_addr); end
        tests++; if (retired_cnt !== 32'd2) begin fails++; $display("FAIL seq_cnt_after: got %0d want 2", retired_cnt); end
        tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL seq_req: got %b want 1", imem_req); end
    endtask

    task automatic test_branch();
        do_fetch(32'h0000_0000);
        consume(1'b1, 1'b0, 16'h0, 26'h80);
        do_fetch(32'h1000_FFFE);
        tests++; if (ir_pc !== 32'h200) begin fails++; $display("FAIL br_ir_pc: got %h want 200", ir_pc); end
        consume(1'b0, 1'b1, 16'hFFFE, 26'h0);
        tests++; if (imem_addr !== 32'h1FC) begin fails++; $display("FAIL br_back: got %h want 1fc", imem_addr); end
        do_fetch(32'h0000_0000);
        consume(1'b1, 1'b0, 16'h0, 26'h80);
        do_fetch(32'h1000_0003);
        consume(1'b0, 1'b1, 16'h0003, 26'h0);
        tests++; if (imem_addr !== 32'h210) begin fails++; $display("FAIL br_fwd: got %h want 210", imem_addr); end
        tests++; if (retired_cnt !== 32'd6) begin fails++; $display("FAIL br_cnt: got %0d want 6", retired_cnt); end
    endtask

    task automatic test_stall();
        ir_ready = 1'b1;
        jump     = 1'b1;
        j_target = 26'h0;
        step();
        ir_ready = 1'b0;
        jump     = 1'b0;
        tests++; if (imem_addr !== 32'h210 || retired_cnt !== 32'd6) begin fails++; $display("FAIL ready_in_fetch: got addr=%h cnt=%0d want 210/6", imem_addr, retired_cnt); end
        do_fetch(32'hAAAA_5555);
        for (int i = 0; i < 10; i++) begin
            imem_ack   = (i % 3 == 0);
            imem_rdata = 32'hDEAD_0000 | i;
            step();
            tests++; if (ir !== 32'hAAAA_5555) begin fails++; $display("FAIL stall_ir[%0d]: got %h want aaaa5555", i, ir); end
            tests++; if (ir_pc !== 32'h210) begin fails++; $display("FAIL stall_ir_pc[%0d]: got %h want 210", i, ir_pc); end
            tests++; if (ir_valid !== 1'b1) begin fails++; $display("FAIL stall_valid[%0d]: got %b want 1", i, ir_valid); end
            tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL stall_req[%0d]: got %b want 0", i, imem_req); end
            tests++; if (retired_cnt !== 32'd6) begin fails++; $display("FAIL stall_cnt[%0d]: got %0d want 6", i, retired_cnt); end
        end
        imem_ack = 1'b0;
    endtask

    task automatic test_jump();
        h_imem_ack   = 1'b1;
        h_imem_rdata = {OPC_J, 26'h40};
        step();
        h_imem_ack   = 1'b0;
        tests++; if (h_ir_valid !== 1'b1 || h_ir_pc !== 32'h4000_0010) begin fails++; $display("FAIL hi_fetch: got valid=%b pc=%h want 1/40000010", h_ir_valid, h_ir_pc); end
        tests++; if (h_ir !== 32'h0800_0040) begin fails++; $display("FAIL hi_ir: got %h want 08000040", h_ir); end
        h_ir_ready   = 1'b1;
        jump         = 1'b1;
        branch_taken = 1'b1;
        br_imm       = 16'h0100;
        j_target     = 26'h40;
        step();
        h_ir_ready   = 1'b0;
        jump         = 1'b0;
        branch_taken = 1'b0;
        tests++; if (h_imem_addr !== 32'h4000_0100) begin fails++; $display("FAIL jump_prio: got %h want 40000100", h_imem_addr); end
        tests++; if (h_imem_req !== 1'b1 || h_retired_cnt !== 32'd1) begin fails++; $display("FAIL hi_consume: got req=%b cnt=%0d want 1/1", h_imem_req, h_retired_cnt); end
        tests++; if (ir_valid !== 1'b1 || retired_cnt !== 32'd6) begin fails++; $display("FAIL no_ready_redirect: got valid=%b cnt=%0d want 1/6", ir_valid, retired_cnt); end
    endtask

    task automatic test_reset_mid_fetch();
        consume(1'b0, 1'b0, 16'h0, 26'h0);
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h214) begin fails++; $display("FAIL pre_rst_fetch: got req=%b addr=%h want 1/214", imem_req, imem_addr); end
        rst_n = 1'b0;
        step();
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL midrst_req: got %b want 0", imem_req); end
        rst_n      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        step();
        imem_ack   = 1'b0;
        tests++; if (ir_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %b want 0", ir_valid); end
        tests++; if (ir !== 32'h0) begin fails++; $display("FAIL midrst_ir: got %h want 0", ir); end
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin fails++; $display("FAIL midrst_refetch: got req=%b addr=%h want 1/0", imem_req, imem_addr); end
        tests++; if (retired_cnt !== 32'd0) begin fails++; $display("FAIL midrst_cnt: got %0d want 0", retired_cnt); end
    endtask

    task automatic test_wrap();
        do_fetch(32'h1000_FFFE);
        tests++; if (ir_pc !== 32'h0 || ir !== 32'h1000_FFFE) begin fails++; $display("FAIL wrap_fetch0: got pc=%h ir=%h want 0/1000fffe", ir_pc, ir); end
        consume(1'b0, 1'b1, 16'hFFFE, 26'h0);
        tests++; if (imem_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_back: got %h want fffffffc", imem_addr); end
        do_fetch(32'h0000_0000);
        tests++; if (ir_pc !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_ir_pc: got %h want fffffffc", ir_pc); end
        tests++; if (pc_plus4 !== 32'h0) begin fails++; $display("FAIL wrap_pc_plus4: got %h want 0", pc_plus4); end
        consume(1'b0, 1'b0, 16'h0, 26'h0);
        tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL wrap_seq: got %h want 0", imem_addr); end
        tests++; if (retired_cnt !== 32'd2) begin fails++; $display("FAIL wrap_cnt: got %0d want 2", retired_cnt); end
    endtask

    initial begin
        rst_n        = 1'b0;
        imem_ack     = 1'b0;
        imem_rdata   = 32'h0;
        ir_ready     = 1'b0;
        jump         = 1'b0;
        branch_taken = 1'b0;
        br_imm       = 16'h0;
        j_target     = 26'h0;
        h_imem_ack   = 1'b0;
        h_imem_rdata = 32'h0;
        h_ir_ready   = 1'b0;
        test_reset();
        test_sequential();
        test_branch();
        test_stall();
        test_jump();
        test_reset_mid_fetch();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
